// File: rtl/idli_pred_m.sv
// rtl/idli_pred_m.sv - predicate file, cond-exec window, slice carry and Z accumulator
// Optional IDLI_PRED_PIN_EN adds a synchronised external pin driving predicate 0.
module idli_pred_m #(
  parameter int NUM_PRED = 4,
  parameter int COND_W   = 8,
  parameter int CTR_W    = 2,
  localparam int PSEL_W  = $clog2(NUM_PRED)
) (
  input  logic                i_pr_gck,
  input  logic                i_pr_rst,
  input  logic [CTR_W-1:0]    i_pr_ctr,
  input  logic                i_pr_vld,
  input  logic                i_pr_stall,
  input  logic                i_pr_cin_raw,
  input  logic                i_pr_alu_z,
  input  logic                i_pr_alu_n,
  input  logic                i_pr_alu_c,
  input  logic                i_pr_alu_v,
  input  logic [2:0]          i_pr_cmp_op,
  input  logic                i_pr_pred_wr,
  input  logic [PSEL_W-1:0]   i_pr_pred_sel,
  input  logic                i_pr_cond_wr,
  input  logic [PSEL_W-1:0]   i_pr_cond_sel,
  input  logic [COND_W-1:0]   i_pr_cond_data,
`ifdef IDLI_PRED_PIN_EN
  input  logic                i_pr_pin,
`endif
  output logic                o_pr_cin,
  output logic                o_pr_skip,
  output logic                o_pr_run,
  output logic [NUM_PRED-1:0] o_pr_pred,
  output logic [COND_W-1:0]   o_pr_cond
);

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_LTU = 3'd3,
    CMP_GE  = 3'd4,
    CMP_GEU = 3'd5,
    CMP_ANY = 3'd6
  } cmp_op_t;

  logic [NUM_PRED-1:0] pred_q, pred_d;
  logic [COND_W-1:0]   cond_q;
  logic [PSEL_W-1:0]   csel_q;
  logic                carry_q;
  logic                zacc_q;

  logic adv, last, first, zw, cmp_res, win_act, end_upd;

  assign adv     = !i_pr_stall;
  assign last    = &i_pr_ctr;
  assign first   = ~|i_pr_ctr;
  assign zw      = i_pr_alu_z && (first || zacc_q);
  assign end_upd = last && adv && i_pr_vld;

  assign o_pr_cin  = first ? i_pr_cin_raw : carry_q;
  assign win_act   = |cond_q[COND_W-1:1];
  assign o_pr_skip = win_act && (cond_q[0] ? !pred_q[csel_q] : pred_q[csel_q]);
  assign o_pr_run  = i_pr_vld && !o_pr_skip;
  assign o_pr_pred = pred_q;
  assign o_pr_cond = cond_q;

  // N, V and C only mean anything on the last slice; Z spans the whole word.
  always_comb begin
    cmp_res = 1'b0;
    case (i_pr_cmp_op)
      CMP_EQ:  cmp_res = zw;
      CMP_NE:  cmp_res = !zw;
      CMP_LT:  cmp_res = i_pr_alu_n != i_pr_alu_v;
      CMP_GE:  cmp_res = i_pr_alu_n == i_pr_alu_v;
      CMP_LTU: cmp_res = !i_pr_alu_c;
      CMP_GEU: cmp_res = i_pr_alu_c;
      CMP_ANY: cmp_res = !zw;
      default: cmp_res = !zw;
    endcase
  end

`ifdef IDLI_PRED_PIN_EN
  logic pin_meta_q, pin_sync_q;

  always_ff @(posedge i_pr_gck or posedge i_pr_rst) begin
    if (i_pr_rst) begin
      pin_meta_q <= 1'b0;
      pin_sync_q <= 1'b0;
    end else begin
      pin_meta_q <= i_pr_pin;
      pin_sync_q <= pin_meta_q;
    end
  end
`endif

  // Pin sample applied first so a same-cycle instruction write to pred 0 overrides it.
  always_comb begin
    pred_d = pred_q;
`ifdef IDLI_PRED_PIN_EN
    if (end_upd) pred_d[0] = pin_sync_q;
`endif
    if (end_upd && o_pr_run && i_pr_pred_wr) pred_d[i_pr_pred_sel] = cmp_res;
  end

  always_ff @(posedge i_pr_gck or posedge i_pr_rst) begin
    if (i_pr_rst) begin
      pred_q  <= '0;
      cond_q  <= '0;
      csel_q  <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b1;
    end else if (adv) begin
      carry_q <= i_pr_alu_c;
      zacc_q  <= last ? 1'b1 : zw;
      pred_q  <= pred_d;
      // Skipped instructions still consume a window slot.
      if (last && i_pr_vld) begin
        if (i_pr_cond_wr && !o_pr_skip) begin
          cond_q <= i_pr_cond_data;
          csel_q <= i_pr_cond_sel;
        end else begin
          cond_q <= {1'b0, cond_q[COND_W-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_idli_pred_m.sv
// tb/tb_idli_pred_m.sv - directed self-checking bench for idli_pred_m
module tb_idli_pred_m;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ctr;
  logic       vld, stall, cin_raw, alu_z, alu_n, alu_c, alu_v;
  logic [2:0] cmp_op;
  logic       pred_wr, cond_wr;
  logic [1:0] pred_sel, cond_sel;
  logic [7:0] cond_data;
  logic       cin, skip, run;
  logic [3:0] pred;
  logic [7:0] cond;
`ifdef IDLI_PRED_PIN_EN
  logic       pin;
`endif

  int checks = 0;
  int failures = 0;
  logic s0, r0;

  always #5 clk = ~clk;

  idli_pred_m dut (
    .i_pr_gck(clk), .i_pr_rst(rst), .i_pr_ctr(ctr), .i_pr_vld(vld), .i_pr_stall(stall),
    .i_pr_cin_raw(cin_raw), .i_pr_alu_z(alu_z), .i_pr_alu_n(alu_n), .i_pr_alu_c(alu_c),
    .i_pr_alu_v(alu_v), .i_pr_cmp_op(cmp_op), .i_pr_pred_wr(pred_wr),
    .i_pr_pred_sel(pred_sel), .i_pr_cond_wr(cond_wr), .i_pr_cond_sel(cond_sel),
    .i_pr_cond_data(cond_data),
`ifdef IDLI_PRED_PIN_EN
    .i_pr_pin(pin),
`endif
    .o_pr_cin(cin), .o_pr_skip(skip), .o_pr_run(run), .o_pr_pred(pred), .o_pr_cond(cond)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 4-slice instruction; zm bit i is slice i's Z, n/c/v apply to the last slice.
  task automatic instr(input logic [2:0] op, input logic pwr, input logic [1:0] psel,
                       input logic cwr, input logic [1:0] csel, input logic [7:0] cdat,
                       input logic [3:0] zm, input logic n, input logic c, input logic v,
                       output logic sk, output logic rn);
    vld = 1'b1; cmp_op = op; pred_wr = pwr; pred_sel = psel;
    cond_wr = cwr; cond_sel = csel; cond_data = cdat;
    for (int i = 0; i < 4; i++) begin
      ctr   = i[1:0];
      alu_z = zm[i];
      alu_n = (i == 3) ? n : 1'b0;
      alu_c = (i == 3) ? c : 1'b0;
      alu_v = (i == 3) ? v : 1'b0;
      #1;
      if (i == 0) begin
        sk = skip;
        rn = run;
      end
      tick();
    end
    vld = 1'b0; pred_wr = 1'b0; cond_wr = 1'b0; ctr = 2'd0;
    alu_z = 1'b0; alu_n = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ctr = 2'd0; vld = 1'b0; stall = 1'b0; cin_raw = 1'b1;
    alu_z = 1'b0; alu_n = 1'b0; alu_c = 1'b0; alu_v = 1'b0; cmp_op = 3'd0;
    pred_wr = 1'b0; cond_wr = 1'b0; pred_sel = 2'd0; cond_sel = 2'd0; cond_data = 8'd0;
`ifdef IDLI_PRED_PIN_EN
    pin = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst_pred", pred, 4'h0);
    chk("rst_cond", cond, 8'h00);
    chk("rst_skip", skip, 1'b0);
    chk("rst_cin_first", cin, 1'b1);
    vld = 1'b1; #1;
    chk("rst_run_vld", run, 1'b1);
    vld = 1'b0; #1;
    chk("rst_run_idle", run, 1'b0);
    cin_raw = 1'b0;

    // EQ into pred 2: all-zero word, then a word with a nonzero slice 2
    instr(3'd0, 1'b1, 2'd2, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 1'b0, 1'b0, s0, r0);
    chk("eq_allz", pred, 4'b0100);
    instr(3'd0, 1'b1, 2'd2, 1'b0, 2'd0, 8'h00, 4'b1011, 1'b0, 1'b0, 1'b0, s0, r0);
    chk("eq_nz", pred, 4'b0000);

    // LT with n=1,v=0 sets pred 1; GEU with c=0 clears it
    instr(3'd2, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, s0, r0);
    chk("lt_set", pred, 4'b0010);
    instr(3'd5, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, s0, r0);
    chk("geu_clr", pred, 4'b0000);
    instr(3'd2, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, s0, r0);

    // Window 0000_0111 on pred 1 (=1, positive): two run, then window empty
    instr(3'd6, 1'b0, 2'd0, 1'b1, 2'd1, 8'h07, 4'b0000, 1'b0, 1'b0, 1'b0, s0, r0);
    chk("cond_load", cond, 8'h07);
    instr(3'd6, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, s0, r0);
    chk("win1_run", r0, 1'b1);
    chk("win1_cond", cond, 8'h03);
    instr(3'd6, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, s0, r0);
    chk("win2_run", r0, 1'b1);
    chk("win2_cond", cond, 8'h01);
    instr(3'd6, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, s0, r0);
    chk("win3_skip", s0, 1'b0);
    chk("win3_cond", cond, 8'h00);

    // Same window with pred 1 = 0: two skipped, their pred writes dropped
    instr(3'd5, 1'b1, 2'd1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, s0, r0);
    instr(3'd6, 1'b0, 2'd0, 1'b1, 2'd1, 8'h07, 4'b0000, 1'b0, 1'b0, 1'b0, s0, r0);
    instr(3'd0, 1'b1, 2'd3, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 1'b0, 1'b0, s0, r0);
    chk("sk1_skip", s0, 1'b1);
    chk("sk1_run", r0, 1'b0);
    chk("sk1_pred", pred, 4'b0000);
    instr(3'd0, 1'b1, 2'd3, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 1'b0, 1'b0, s0, r0);
    chk("sk2_skip", s0, 1'b1);
    chk("sk2_pred", pred, 4'b0000);
    instr(3'd0, 1'b1, 2'd3, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 1'b0, 1'b0, s0, r0);
    chk("sk3_run", r0, 1'b1);
    chk("sk3_pred", pred, 4'b1000);

    // Stall at slice 1 for 3 cycles: carry and Z accumulator must hold
    vld = 1'b1; cmp_op = 3'd0; pred_wr = 1'b1; pred_sel = 2'd2;
    ctr = 2'd0; alu_z = 1'b1; alu_c = 1'b1; #1;
    chk("stall_cin_first", cin, 1'b0);
    tick();
    ctr = 2'd1; stall = 1'b1; alu_z = 1'b0; alu_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_cin_hold", cin, 1'b1);
      tick();
    end
    stall = 1'b0; alu_z = 1'b1; #1;
    chk("stall_cin_resume", cin, 1'b1);
    tick();
    ctr = 2'd2; #1;
    chk("stall_cin_s2", cin, 1'b0);
    tick();
    ctr = 2'd3; tick();
    vld = 1'b0; pred_wr = 1'b0; ctr = 2'd0; alu_z = 1'b0;
    chk("stall_zacc_pred", pred, 4'b1100);

    // Window 0000_0110 on pred 2 (=1, negative polarity) skips; reset at slice 2
    instr(3'd6, 1'b0, 2'd0, 1'b1, 2'd2, 8'h06, 4'b0000, 1'b0, 1'b0, 1'b0, s0, r0);
    vld = 1'b1; cin_raw = 1'b1; ctr = 2'd0; alu_c = 1'b1; #1;
    chk("pre_rst_skip", skip, 1'b1);
    tick();
    ctr = 2'd1; tick();
    ctr = 2'd2; #1;
    chk("pre_rst_cin", cin, 1'b1);
    rst = 1'b1; #1;
    chk("mid_rst_pred", pred, 4'h0);
    chk("mid_rst_cond", cond, 8'h00);
    chk("mid_rst_skip", skip, 1'b0);
    chk("mid_rst_cin", cin, 1'b0);
    chk("mid_rst_run", run, 1'b1);
    tick();
    rst = 1'b0; ctr = 2'd0; vld = 1'b0; alu_c = 1'b0; #1;
    chk("post_rst_cin", cin, 1'b1);
    tick();

`ifdef IDLI_PRED_PIN_EN
    pin = 1'b1;
    instr(3'd6, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, s0, r0);
    chk("pin_pred0", pred, 4'b0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
